// File: rtl/prog_loader_pkg.sv
// Shared types and default widths for the program loader and its environment.
package prog_loader_pkg;

  localparam int unsigned PlAddrW = 8;
  localparam int unsigned PlDataW = 32;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StRun,
    StError
  } pl_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Word-stream source handshake plus program-memory write port and core control.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = prog_loader_pkg::PlAddrW,
  parameter int unsigned DATA_W = prog_loader_pkg::PlDataW
);

  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              prog_w;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              cpu_clr;
  logic              busy;
  logic              done;
  logic              err;

  // Controller/source side.
  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, prog_w, prog_addr, prog_data, cpu_clr, busy, done, err
  );

  // Loader side.
  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, prog_w, prog_addr, prog_data, cpu_clr, busy, done, err
  );

endinterface

// File: rtl/prog_loader.sv
// Program loader: optionally zero-fills program memory, then streams words into it
// and holds the core in reset until a complete program has been written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = PlAddrW,
  parameter int unsigned DATA_W    = PlDataW,
  parameter bit          CLEAR_MEM = 1'b1
) (
  input  logic         clk,
  input  logic         clr,
  prog_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] CntMax = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CntOne = ADDR_W'(1);

  pl_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [DATA_W-1:0] prog_data_q, prog_data_d;
  logic              prog_w_q, prog_w_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_clr_q, cpu_clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hs;

  // State register; clr wins over everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, shared clear/word counter and registered output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prog_w_d    = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    hs          = (state_q == StLoad) && in_ready_q && bus.in_valid;

    unique case (state_q)
      StIdle, StRun, StError: begin
        if (bus.start) begin
          state_d = CLEAR_MEM ? StClear : StLoad;
          cnt_d   = '0;
        end
      end
      StClear: begin
        prog_w_d    = 1'b1;
        prog_addr_d = cnt_q;
        prog_data_d = '0;
        if (cnt_q == CntMax) begin
          state_d = StLoad;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StLoad: begin
        if (hs) begin
          prog_w_d    = 1'b1;
          prog_addr_d = cnt_q;
          prog_data_d = bus.in_data;
          if (bus.in_last) begin
            state_d = StRun;
          end else if (cnt_q == CntMax) begin
            // Memory full but the program keeps going.
            state_d = StError;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Ready only once settled in LOAD, and dropped on the accepting edge of the last word.
    in_ready_d = (state_q == StLoad) && (state_d == StLoad);
    cpu_clr_d  = (state_q != StRun);
    busy_d     = (state_q == StClear) || (state_q == StLoad);
    done_d     = (state_q == StRun);
    err_d      = (state_q == StError);
  end

  // Output and counter registers; a handshake coinciding with clr is dropped.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q       <= '0;
      prog_w_q    <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      in_ready_q  <= 1'b0;
      cpu_clr_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prog_w_q    <= prog_w_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      in_ready_q  <= in_ready_d;
      cpu_clr_q   <= cpu_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.prog_w    = prog_w_q;
  assign bus.prog_addr = prog_addr_q;
  assign bus.prog_data = prog_data_q;
  assign bus.cpu_clr   = cpu_clr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: clear sweep, loads, overflow, resets and ignored starts.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(PlAddrW), .DATA_W(PlDataW)) bus ();

  prog_loader #(
    .ADDR_W   (PlAddrW),
    .DATA_W   (PlDataW),
    .CLEAR_MEM(1'b1)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Write log, captured on the edge that ends each write cycle.
  logic [7:0]  wa[$];
  logic [31:0] wd[$];

  always @(posedge clk) begin
    if (bus.prog_w === 1'b1) begin
      wa.push_back(bus.prog_addr);
      wd.push_back(bus.prog_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; start is seen by the next rising edge.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) check(tag, bus.in_ready, 1'b1);
  endtask

  // Called at a falling edge; returns at the falling edge of the write cycle.
  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) check("send_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, bad, first_w, first_rdy;

    clr          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);

    // Reset values.
    check("rst_prog_w", bus.prog_w, 1'b0);
    check("rst_addr", bus.prog_addr, 8'h00);
    check("rst_data", bus.prog_data, 32'h0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_cpu_clr", bus.cpu_clr, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);

    // Clear sweep: writes in cycles 2..257 after start, ready in cycle 258.
    pulse_start();
    pulses = 0; bad = 0; first_w = 0; first_rdy = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.prog_w === 1'b1) begin
        if (first_w == 0) first_w = k;
        if (bus.prog_addr !== 8'(pulses)) bad++;
        if (bus.prog_data !== 32'h0) bad++;
        pulses++;
      end
      if (bus.in_ready === 1'b1) begin
        first_rdy = k;
        break;
      end
    end
    check("clr_pulses", 64'(pulses), 64'd256);
    check("clr_addr_data_bad", 64'(bad), 64'd0);
    check("clr_first_write_cycle", 64'(first_w), 64'd2);
    check("clr_ready_cycle", 64'(first_rdy), 64'd258);
    check("clr_busy", bus.busy, 1'b1);
    check("clr_cpu_clr", bus.cpu_clr, 1'b1);

    // Eight-word program.
    wa.delete(); wd.delete();
    for (int i = 0; i < 8; i++) send(32'h2008_0001 + 32'(i), i == 7);
    check("l8_ready_drop", bus.in_ready, 1'b0);
    check("l8_last_w", bus.prog_w, 1'b1);
    check("l8_last_addr", bus.prog_addr, 8'd7);
    check("l8_cpu_clr_hold", bus.cpu_clr, 1'b1);
    check("l8_done_early", bus.done, 1'b0);
    @(negedge clk);
    check("l8_cpu_clr", bus.cpu_clr, 1'b0);
    check("l8_done", bus.done, 1'b1);
    check("l8_busy", bus.busy, 1'b0);
    check("l8_w_idle", bus.prog_w, 1'b0);
    check("l8_addr_hold", bus.prog_addr, 8'd7);
    check("l8_data_hold", bus.prog_data, 32'h2008_0008);
    check("l8_count", 64'(wa.size()), 64'd8);
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      check($sformatf("l8_addr%0d", i), wa[i], 8'(i));
      check($sformatf("l8_data%0d", i), wd[i], 32'h2008_0001 + 32'(i));
    end

    // Restart from RUN; valid held through CLEAR must not be consumed; toggling valid.
    pulse_start();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1111_0000;
    bus.in_last  = 1'b0;
    wait_ready("tog_ready");
    wa.delete(); wd.delete();
    send(32'h1111_0000, 1'b0);
    @(negedge clk);
    send(32'h2222_0000, 1'b0);
    @(negedge clk);
    send(32'h3333_0000, 1'b1);
    @(negedge clk);
    check("tog_count", 64'(wa.size()), 64'd3);
    if (wa.size() == 3) begin
      check("tog_addr0", wa[0], 8'd0);
      check("tog_addr1", wa[1], 8'd1);
      check("tog_addr2", wa[2], 8'd2);
      check("tog_data0", wd[0], 32'h1111_0000);
      check("tog_data2", wd[2], 32'h3333_0000);
    end
    check("tog_done", bus.done, 1'b1);

    // clr after 100 clear writes, then a fresh start restarts at address 0.
    pulse_start();
    pulses = 0;
    for (int k = 0; k < 300 && pulses < 100; k++) begin
      @(negedge clk);
      if (bus.prog_w === 1'b1) pulses++;
    end
    check("abort_addr99", bus.prog_addr, 8'd99);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("abort_prog_w", bus.prog_w, 1'b0);
    check("abort_cpu_clr", bus.cpu_clr, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_addr", bus.prog_addr, 8'd0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.prog_w !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("idle_ignores_valid", 64'(bad), 64'd0);
    bus.in_valid = 1'b0;
    pulse_start();
    first_w = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.prog_w === 1'b1) begin
        first_w = int'(bus.prog_addr);
        break;
      end
    end
    check("restart_addr0", 64'(first_w), 64'd0);
    wait_ready("restart_ready");

    // start during LOAD is ignored.
    wa.delete(); wd.delete();
    for (int i = 0; i < 4; i++) send(32'h4000_0001 + 32'(i), 1'b0);
    pulse_start();
    @(negedge clk);
    check("ld_start_busy", bus.busy, 1'b1);
    check("ld_start_ready", bus.in_ready, 1'b1);
    send(32'h4000_0005, 1'b1);
    @(negedge clk);
    check("ld_start_done", bus.done, 1'b1);
    check("ld_start_count", 64'(wa.size()), 64'd5);
    if (wa.size() == 5) begin
      check("ld_start_addr4", wa[4], 8'd4);
      check("ld_start_data4", wd[4], 32'h4000_0005);
    end

    // Handshake in the clr cycle is discarded.
    pulse_start();
    wait_ready("rstwr_ready");
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    bus.in_last  = 1'b1;
    clr          = 1'b1;
    @(posedge clk);
    #1;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    check("rstwr_prog_w", bus.prog_w, 1'b0);
    check("rstwr_data", bus.prog_data, 32'h0);
    @(negedge clk);
    check("rstwr_done", bus.done, 1'b0);

    // 256 words without last -> overflow error.
    pulse_start();
    wait_ready("ovf_ready");
    wa.delete(); wd.delete();
    for (int i = 0; i < 256; i++) send(32'h3800_0000 + 32'(i), 1'b0);
    check("ovf_ready_drop", bus.in_ready, 1'b0);
    check("ovf_last_addr", bus.prog_addr, 8'd255);
    check("ovf_last_w", bus.prog_w, 1'b1);
    @(negedge clk);
    check("ovf_err", bus.err, 1'b1);
    check("ovf_cpu_clr", bus.cpu_clr, 1'b1);
    check("ovf_done", bus.done, 1'b0);
    check("ovf_busy", bus.busy, 1'b0);
    check("ovf_count", 64'(wa.size()), 64'd256);
    bad = 0;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] !== 8'(i) || wd[i] !== 32'h3800_0000 + 32'(i)) bad++;
    end
    check("ovf_addr_data_bad", 64'(bad), 64'd0);
    @(negedge clk);
    check("ovf_w_idle", bus.prog_w, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
